// File: rtl/maze_bus_if.sv
// maze_bus_if -- controller-side control signals of the maze memory bus.
//
// Carries the cell address, the transfer direction and the active-low bus
// enable from the game controller to the maze memory. The shared data lines
// stay a plain inout on the responder so that the tri-state net resolves
// between the controller, the memory and any pull on the board.
//
// Signals:
//   address    [5:0] cell address, [5:3]=row, [2:0]=column (may float when idle)
//   commend          1=controller reads, 0=controller writes, Z=idle
//   NVcommend        bus enable, active-low
//
// Modports:
//   master : controller side (drives everything)
//   slave  : maze memory side (observes everything)
interface maze_bus_if;
    logic [5:0] address;
    logic       commend;
    logic       NVcommend;

    modport master (
        output address,
        output commend,
        output NVcommend
    );

    modport slave (
        input address,
        input commend,
        input NVcommend
    );
endinterface

// File: rtl/maze_mem.sv
// maze_mem -- responder end of the maze-controller memory bus.
//
// Holds a 64-cell maze map, DATA_W bits per cell (0=empty, 1=wall,
// 2=player, 3=illegal). After reset an init sequencer loads the default
// layout (LAYOUT wall mask, START_ADDR overridden with the player), one cell
// per clock for 64 clocks; ready rises on the first cycle afterwards.
// In RUN the block answers controller reads combinationally on the shared
// data bus, accepts controller writes on the clock edge, and serves a
// registered scan port for the display driver.
//
// Ports:
//   clk        system clock
//   nst        reset, asynchronous, active-high
//   bus        maze_bus_if.slave: address / commend / NVcommend
//   data       shared tri-state data bus (driven only for a valid read in RUN)
//   scan_addr  display scan address
//   scan_data  registered cell value at scan_addr (one-cycle latency)
//   ready      high once the default layout has been loaded
//   err        sticky illegal-write flag, cleared only by nst
//
// Build option:
//   WALL_PROTECT_EN  when defined, RUN-time writes to cells marked in LAYOUT
//                    are refused and flag err, except writes of the wall
//                    value itself, which are accepted silently.
module maze_mem #(
    parameter int          DATA_W     = 2,
    parameter logic [63:0] LAYOUT     = 64'h0,
    parameter logic [5:0]  START_ADDR = 6'd0
) (
    input  logic              clk,
    input  logic              nst,
    maze_bus_if.slave         bus,
    inout  wire  [DATA_W-1:0] data,
    input  logic [5:0]        scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              ready,
    output logic              err
);

    localparam logic [DATA_W-1:0] CELL_EMPTY   = DATA_W'(0);
    localparam logic [DATA_W-1:0] CELL_WALL    = DATA_W'(1);
    localparam logic [DATA_W-1:0] CELL_PLAYER  = DATA_W'(2);
    localparam logic [DATA_W-1:0] CELL_ILLEGAL = DATA_W'(3);
    localparam logic [5:0]        LAST_CELL    = 6'd63;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [5:0]        init_cnt_r;
    logic [DATA_W-1:0] mem_r [64];

    logic              phase_valid_s;
    logic              addr_known_s;
    logic              rd_drive_s;
    logic              wr_req_s;
    logic              wall_hit_s;
    logic              violation_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rd_val_s;

    // Default content of one cell: the player start overrides the wall mask.
    function automatic logic [DATA_W-1:0] init_value(input logic [5:0] idx);
        if (idx == START_ADDR) begin
            return CELL_PLAYER;
        end else if (LAYOUT[idx]) begin
            return CELL_WALL;
        end else begin
            return CELL_EMPTY;
        end
    endfunction

    // Bus phase decode. Case equality keeps a floating commend or enable
    // from being mistaken for an access; an unknown address blocks writes.
    always_comb begin
        phase_valid_s = (bus.NVcommend === 1'b0) &&
                        ((bus.commend === 1'b0) || (bus.commend === 1'b1));
        addr_known_s  = ((^bus.address) !== 1'bx);
        wdata_s       = data;
        rd_val_s      = mem_r[bus.address];
        rd_drive_s    = phase_valid_s && (bus.commend === 1'b1) && ready;
        wr_req_s      = phase_valid_s && (bus.commend === 1'b0) &&
                        addr_known_s && (state_r == ST_RUN);
`ifdef WALL_PROTECT_EN
        // Wall painting (value 1) onto a wall is harmless and accepted.
        wall_hit_s    = LAYOUT[bus.address] && (wdata_s != CELL_WALL);
`else
        wall_hit_s    = 1'b0;
`endif
        violation_s   = wr_req_s && ((wdata_s == CELL_ILLEGAL) || wall_hit_s);
        mem_we_s      = wr_req_s && !violation_s;
    end

    // Zero-latency read path: follows address within the same cycle.
    assign data = rd_drive_s ? rd_val_s : {DATA_W{1'bz}};

    // Next-state logic of the init/run sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_CELL) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Sequencer state, init counter and registered outputs.
    always_ff @(posedge clk or posedge nst) begin
        if (nst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= 6'd0;
            ready      <= 1'b0;
            err        <= 1'b0;
            scan_data  <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_s;
            ready   <= (state_s == ST_RUN);
            if (state_r == ST_INIT) begin
                // Wraps 63->0 on the last load; unused afterwards.
                init_cnt_r <= init_cnt_r + 6'd1;
            end
            if (violation_s) begin
                err <= 1'b1;
            end
            // Reads the pre-write array, so a same-cycle write shows next scan.
            if (state_r == ST_RUN) begin
                scan_data <= mem_r[scan_addr];
            end else begin
                scan_data <= {DATA_W{1'b0}};
            end
        end
    end

    // Map storage: layout load during INIT, controller writes during RUN.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[init_cnt_r] <= init_value(init_cnt_r);
        end else if (mem_we_s) begin
            mem_r[bus.address] <= wdata_s;
        end
    end

endmodule
